multi_key_detect: RTL and testbench

//  Parametrised N-channel key front end: synchronises raw key pins, debounces each channel, and emits
//  one-cycle press/release/hold pulses plus a stable level per key. Sits between board key pins and

---
 rtl/multi_key_detect.sv | 167 ++++++++++++++++
 tb/tb_multi_key_detect.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multi_key_detect.sv
// N-channel key front end: synchronise, debounce, and emit press/release/hold pulses
// plus a stable pressed level per key, gated by a power-up blanking window.
module multi_key_detect #(
    parameter int unsigned N_KEYS     = 4,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned BLANK_CYC  = 5000,
    parameter int unsigned DB_CYC     = 500000,
    parameter int unsigned HOLD_CYC   = 50000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_KEYS-1:0] Pin_In,
    output logic [N_KEYS-1:0] Key_State,
    output logic [N_KEYS-1:0] Press_Sig,
    output logic [N_KEYS-1:0] Release_Sig,
    output logic [N_KEYS-1:0] Hold_Sig,
    output logic              Ready
);

    localparam int unsigned BLANK_W = $clog2((BLANK_CYC > 2) ? BLANK_CYC : 2) + 1;
    localparam int unsigned DB_W    = $clog2((DB_CYC > 2) ? DB_CYC : 2) + 1;
    localparam int unsigned HOLD_W  = $clog2((HOLD_CYC > 2) ? HOLD_CYC : 2) + 1;

    localparam int unsigned BLANK_LAST_I = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam int unsigned DB_LAST_I    = (DB_CYC > 0) ? DB_CYC - 1 : 0;
    localparam int unsigned HOLD_LAST_I  = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_LAST_I);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_LAST_I);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_LAST_I);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYC);
    localparam bit                 HOLD_EN    = (HOLD_CYC != 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic                ready_q, ready_d;

    logic [N_KEYS-1:0]   pin_norm;
    logic [N_KEYS-1:0]   sync1_q, sync2_q;

    logic [N_KEYS-1:0]   key_q, key_d;
    logic [N_KEYS-1:0]   press_q, press_d;
    logic [N_KEYS-1:0]   rel_q, rel_d;
    logic [N_KEYS-1:0]   hold_sig_q, hold_sig_d;

    logic [N_KEYS-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [N_KEYS-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Normalise polarity so that 1 always means pressed downstream.
    assign pin_norm = ACTIVE_LOW ? ~Pin_In : Pin_In;

    // Two-flop synchroniser; reset value is the released level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_norm;
            sync2_q <= sync1_q;
        end
    end

    // Blanking window state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_BLANK;
            blank_cnt_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            ready_q     <= ready_d;
        end
    end

    // Blanking next-state: count edges until the window has elapsed, then stay in RUN.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        ready_d     = 1'b0;
        case (state_q)
            ST_BLANK: begin
                blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase
    end

    // Per-channel debounce and hold timing; channels never interact.
    always_comb begin
        key_d      = key_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = '0;
        rel_d      = '0;
        hold_sig_d = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (!ready_q) begin
                // Track the pin silently so a key held at power-up never reports a press.
                key_d[i]      = sync2_q[i];
                db_cnt_d[i]   = '0;
                hold_cnt_d[i] = '0;
            end else begin
                if (sync2_q[i] == key_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    key_d[i]    = sync2_q[i];
                    db_cnt_d[i] = '0;
                    press_d[i]  = sync2_q[i];
                    rel_d[i]    = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end

                // Saturating hold counter gives exactly one pulse per press.
                if (!HOLD_EN || !key_q[i]) begin
                    hold_cnt_d[i] = '0;
                end else if (hold_cnt_q[i] < HOLD_MAX) begin
                    hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
                    if (hold_cnt_q[i] == HOLD_LAST) begin
                        hold_sig_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Channel state and pulse registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_q      <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            hold_sig_q <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            key_q      <= key_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            hold_sig_q <= hold_sig_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign Key_State   = key_q;
    assign Press_Sig   = press_q;
    assign Release_Sig = rel_q;
    assign Hold_Sig    = hold_sig_q;
    assign Ready       = ready_q;

endmodule

// File: tb/tb_multi_key_detect.sv
// Directed scoreboard bench for multi_key_detect (2 keys, active-low, short timing windows).
module tb_multi_key_detect;

    logic       CLK;
    logic       RST_N;
    logic [1:0] Pin_In;
    logic [1:0] Key_State;
    logic [1:0] Press_Sig;
    logic [1:0] Release_Sig;
    logic [1:0] Hold_Sig;
    logic       Ready;

    typedef struct {
        string      tag;
        logic [1:0] key;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] hld;
        logic       rdy;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    multi_key_detect #(
        .N_KEYS    (2),
        .ACTIVE_LOW(1'b1),
        .BLANK_CYC (8),
        .DB_CYC    (4),
        .HOLD_CYC  (10)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Pin_In     (Pin_In),
        .Key_State  (Key_State),
        .Press_Sig  (Press_Sig),
        .Release_Sig(Release_Sig),
        .Hold_Sig   (Hold_Sig),
        .Ready      (Ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push(input string tag, input int n, input logic [1:0] key, input logic [1:0] prs,
                        input logic [1:0] rel, input logic [1:0] hld, input logic rdy);
        exp_t e;
        e.tag = tag;
        e.key = key;
        e.prs = prs;
        e.rel = rel;
        e.hld = hld;
        e.rdy = rdy;
        repeat (n) sbq.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic sample_now();
        exp_t e;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow at %0t observed=empty expected=entry", $time);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({e.tag, "_key"},   Key_State,      e.key);
            chk({e.tag, "_press"}, Press_Sig,      e.prs);
            chk({e.tag, "_rel"},   Release_Sig,    e.rel);
            chk({e.tag, "_hold"},  Hold_Sig,       e.hld);
            chk({e.tag, "_ready"}, {1'b0, Ready},  {1'b0, e.rdy});
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        sample_now();
    endtask

    task automatic drain();
        while (sbq.size() != 0) step();
    endtask

    initial begin
        RST_N  = 1'b0;
        Pin_In = 2'b11;

        // Reset then blanking: Ready rises on the 8th edge after release
        push("rst", 3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        drain();
        RST_N = 1'b1;
        push("blank", 7, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push("ready", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();

        // Clean press on ch0: pulse 5 edges after the pin change, then clean release
        Pin_In = 2'b10;
        push("t2_wait",  5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t2_press", 1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
        push("t2_held",  1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();
        Pin_In = 2'b11;
        push("t2_rwait", 5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t2_rel",   1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1);
        push("t2_idle",  1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();

        // Three-cycle glitch on ch0 is one short of the debounce window
        push("t3_glitch", 10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        Pin_In = 2'b10;
        repeat (3) step();
        Pin_In = 2'b11;
        drain();

        // Long press on ch1: press, one hold pulse 10 edges later, then release
        Pin_In = 2'b01;
        push("t4_wait",  5,  2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t4_press", 1,  2'b10, 2'b10, 2'b00, 2'b00, 1'b1);
        push("t4_pre",   9,  2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t4_hold",  1,  2'b10, 2'b00, 2'b00, 2'b10, 1'b1);
        push("t4_post",  14, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();
        Pin_In = 2'b11;
        push("t4_rwait", 5, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t4_rel",   1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1);
        push("t4_idle",  2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();

        // Both keys down through reset and blanking: level reported, no press pulse
        Pin_In = 2'b00;
        RST_N  = 1'b0;
        #1;
        push("t5_rst_now", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        sample_now();
        push("t5_rst", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        drain();
        RST_N = 1'b1;
        push("t5_sync",  2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push("t5_blank", 5, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        push("t5_ready", 1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t5_quiet", 4, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();

        // Reset while keys are reported pressed clears the level immediately
        RST_N = 1'b0;
        #1;
        push("rst_mid_now", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        sample_now();
        Pin_In = 2'b11;
        push("rst_mid", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        drain();
        RST_N = 1'b1;
        push("reblank", 7, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push("reready", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();

        // Both pins drop together, reset lands mid-debounce, keys reappear as level only
        Pin_In = 2'b00;
        push("t6_deb", 3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();
        RST_N = 1'b0;
        #1;
        push("t6_rst_now", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        sample_now();
        push("t6_rst", 2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        drain();
        RST_N = 1'b1;
        push("t6_sync",  2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push("t6_blank", 5, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        push("t6_ready", 1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
        push("t6_quiet", 6, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();
        Pin_In = 2'b11;

        chk("sb_drained", (sbq.size() == 0) ? 2'b01 : 2'b00, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
